// File: rtl/decoder_10b8b.sv
// decoder_10b8b: registered 8b/10b symbol decoder with running-disparity tracking.
// Splits each 10-bit symbol into its 6b (abcdei) and 4b (fghj) sub-blocks.
// It decodes both sub-blocks, flags K characters, code violations and disparity
// violations, and keeps the running disparity in a register.
// Optional feature: define DEC_ERR_CNT_EN to add a saturating 16-bit error
// counter (CNT_CLR / ERR_CNT).
module decoder_10b8b #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IVAL,
    input  logic [9:0]  DI,
    output logic        OVAL,
    output logic [7:0]  DO,
    output logic        KO,
    output logic        CERR,
    output logic        DERR,
    output logic        RD
`ifdef DEC_ERR_CNT_EN
    ,
    input  logic        CNT_CLR,
    output logic [15:0] ERR_CNT
`endif
);

    logic [5:0] code6;
    logic [3:0] code4;
    logic [3:0] code4Eff;
    logic [2:0] ones6;
    logic [2:0] ones4;
    logic [4:0] dec5;
    logic [2:0] dec3;
    logic       kNext;
    logic       cerrNext;
    logic       derrNext;
    logic       rdMid;
    logic       rdNext;

    function automatic logic [2:0] countOnes6(input logic [5:0] v);
        countOnes6 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]}
                   + {2'b00, v[3]} + {2'b00, v[4]} + {2'b00, v[5]};
    endfunction

    function automatic logic [2:0] countOnes4(input logic [3:0] v);
        countOnes4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    assign code6 = DI[9:4];
    assign code4 = DI[3:0];
    assign ones6 = countOnes6(code6);
    assign ones4 = countOnes4(code4);

    // K28 on the RD+ side (110000) carries a complemented fghj, so it is un-inverted before lookup
    assign code4Eff = (code6 == 6'b110000) ? ~code4 : code4;

    // 6b sub-block lookup: abcdei to EDCBA, both disparity variants map to the same value
    always_comb begin
        dec5 = 5'd0;
        case (code6)
            6'b100111, 6'b011000: dec5 = 5'd0;
            6'b011101, 6'b100010: dec5 = 5'd1;
            6'b101101, 6'b010010: dec5 = 5'd2;
            6'b110001:            dec5 = 5'd3;
            6'b110101, 6'b001010: dec5 = 5'd4;
            6'b101001:            dec5 = 5'd5;
            6'b011001:            dec5 = 5'd6;
            6'b111000, 6'b000111: dec5 = 5'd7;
            6'b111001, 6'b000110: dec5 = 5'd8;
            6'b100101:            dec5 = 5'd9;
            6'b010101:            dec5 = 5'd10;
            6'b110100:            dec5 = 5'd11;
            6'b001101:            dec5 = 5'd12;
            6'b101100:            dec5 = 5'd13;
            6'b011100:            dec5 = 5'd14;
            6'b010111, 6'b101000: dec5 = 5'd15;
            6'b011011, 6'b100100: dec5 = 5'd16;
            6'b100011:            dec5 = 5'd17;
            6'b010011:            dec5 = 5'd18;
            6'b110010:            dec5 = 5'd19;
            6'b001011:            dec5 = 5'd20;
            6'b101010:            dec5 = 5'd21;
            6'b011010:            dec5 = 5'd22;
            6'b111010, 6'b000101: dec5 = 5'd23;
            6'b110011, 6'b001100: dec5 = 5'd24;
            6'b100110:            dec5 = 5'd25;
            6'b010110:            dec5 = 5'd26;
            6'b110110, 6'b001001: dec5 = 5'd27;
            6'b001110:            dec5 = 5'd28;
            6'b101110, 6'b010001: dec5 = 5'd29;
            6'b011110, 6'b100001: dec5 = 5'd30;
            6'b101011, 6'b010100: dec5 = 5'd31;
            6'b001111, 6'b110000: dec5 = 5'd28;
            default:              dec5 = 5'd0;
        endcase
    end

    // 4b sub-block lookup: fghj to HGF, primary and alternate x.7 both decode to 7
    always_comb begin
        dec3 = 3'd0;
        case (code4Eff)
            4'b1011, 4'b0100:                   dec3 = 3'd0;
            4'b1001:                            dec3 = 3'd1;
            4'b0101:                            dec3 = 3'd2;
            4'b1100, 4'b0011:                   dec3 = 3'd3;
            4'b1101, 4'b0010:                   dec3 = 3'd4;
            4'b1010:                            dec3 = 3'd5;
            4'b0110:                            dec3 = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
            default:                            dec3 = 3'd0;
        endcase
    end

    // K detection plus code-table membership of the 6b/4b pair
    always_comb begin
        logic valid6;
        logic valid4;
        logic pos6;
        logic neg6;
        logic pairOk;
        logic kx7Code;

        kx7Code = (code6 == 6'b111010) || (code6 == 6'b110110) ||
                  (code6 == 6'b101110) || (code6 == 6'b011110) ||
                  (code6 == 6'b000101) || (code6 == 6'b001001) ||
                  (code6 == 6'b010001) || (code6 == 6'b100001);
        kNext = (code6 == 6'b001111) || (code6 == 6'b110000) ||
                (((code4 == 4'b0111) || (code4 == 4'b1000)) && kx7Code);

        valid6 = (ones6 >= 3'd2) && (ones6 <= 3'd4) &&
                 (code6 != 6'b111100) && (code6 != 6'b000011);
        valid4 = (ones4 >= 3'd1) && (ones4 <= 3'd3);

        // A 6b code that leaves the line at RD+ must be followed by an RD+ 4b code, and vice versa
        pos6 = (ones6 > 3'd3) || (code6 == 6'b000111);
        neg6 = (ones6 < 3'd3) || (code6 == 6'b111000);
        pairOk = 1'b1;
        if (pos6 && ((ones4 > 3'd2) || (code4 == 4'b1100))) begin
            pairOk = 1'b0;
        end
        if (neg6 && ((ones4 < 3'd2) || (code4 == 4'b0011))) begin
            pairOk = 1'b0;
        end

        // Alternate x.7 only follows the specific 6b codes that would otherwise create a run of five
        if ((code4 == 4'b0111) &&
            !((code6 == 6'b100011) || (code6 == 6'b010011) || (code6 == 6'b001011) ||
              (code6 == 6'b000101) || (code6 == 6'b001001) || (code6 == 6'b010001) ||
              (code6 == 6'b100001) || (code6 == 6'b110000))) begin
            pairOk = 1'b0;
        end
        if ((code4 == 4'b1000) &&
            !((code6 == 6'b110100) || (code6 == 6'b101100) || (code6 == 6'b011100) ||
              (code6 == 6'b111010) || (code6 == 6'b110110) || (code6 == 6'b101110) ||
              (code6 == 6'b011110) || (code6 == 6'b001111))) begin
            pairOk = 1'b0;
        end
        if ((code4 == 4'b1110) &&
            ((code6 == 6'b100011) || (code6 == 6'b010011) ||
             (code6 == 6'b001011) || (code6 == 6'b110000))) begin
            pairOk = 1'b0;
        end
        if ((code4 == 4'b0001) &&
            ((code6 == 6'b110100) || (code6 == 6'b101100) ||
             (code6 == 6'b011100) || (code6 == 6'b001111))) begin
            pairOk = 1'b0;
        end

        cerrNext = !valid6 || !valid4 || !pairOk;
    end

    // Disparity check of each sub-block against the running disparity it starts from
    always_comb begin
        logic derr6;
        logic derr4;

        derr6 = (!RD && (ones6 < 3'd3)) || (RD && (ones6 > 3'd3)) ||
                (RD && (code6 == 6'b000111)) || (!RD && (code6 == 6'b111000));
        if (ones6 > 3'd3) begin
            rdMid = 1'b1;
        end else if (ones6 < 3'd3) begin
            rdMid = 1'b0;
        end else begin
            rdMid = RD;
        end

        derr4 = (!rdMid && (ones4 < 3'd2)) || (rdMid && (ones4 > 3'd2)) ||
                (rdMid && (code4 == 4'b0011)) || (!rdMid && (code4 == 4'b1100));
        if (ones4 > 3'd2) begin
            rdNext = 1'b1;
        end else if (ones4 < 3'd2) begin
            rdNext = 1'b0;
        end else begin
            rdNext = rdMid;
        end

        derrNext = derr6 || derr4;
    end

    // Output and running-disparity registers, loaded only on symbol cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVAL <= 1'b0;
            DO   <= 8'h00;
            KO   <= 1'b0;
            CERR <= 1'b0;
            DERR <= 1'b0;
            RD   <= RD_INIT;
        end else begin
            OVAL <= IVAL;
            if (IVAL) begin
                DO   <= {dec3, dec5};
                KO   <= kNext;
                CERR <= cerrNext;
                DERR <= derrNext;
                RD   <= rdNext;
            end
        end
    end

`ifdef DEC_ERR_CNT_EN
    // Saturating count of erroneous symbols; clear wins over a same-cycle increment
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_CNT <= 16'h0000;
        end else if (CNT_CLR) begin
            ERR_CNT <= 16'h0000;
        end else if (IVAL && (cerrNext || derrNext) && (ERR_CNT != 16'hFFFF)) begin
            ERR_CNT <= ERR_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_10b8b.sv
// tb_decoder_10b8b: directed-vector scoreboard bench for decoder_10b8b.
// Each applied symbol pushes its hand-computed result into a queue.
// A monitor pops the queue and compares whenever OVAL is high.
// Define DEC_ERR_CNT_EN to also exercise the error counter.
module tb_decoder_10b8b;

    typedef struct {
        logic [9:0] di;
        logic [7:0] dout;
        logic       doCare;
        logic       ko;
        logic       cerr;
        logic       derr;
        logic       rd;
    } expT;

    logic        clk;
    logic        rstN;
    logic        ival;
    logic [9:0]  di;
    logic        oval;
    logic [7:0]  dout;
    logic        ko;
    logic        cerr;
    logic        derr;
    logic        rd;
`ifdef DEC_ERR_CNT_EN
    logic        cntClr;
    logic [15:0] errCnt;
`endif

    expT expQ[$];
    int  compareCount = 0;
    int  missCount    = 0;

    decoder_10b8b #(.RD_INIT(1'b0)) dut (
        .CLK   (clk),
        .RST_N (rstN),
        .IVAL  (ival),
        .DI    (di),
        .OVAL  (oval),
        .DO    (dout),
        .KO    (ko),
        .CERR  (cerr),
        .DERR  (derr),
        .RD    (rd)
`ifdef DEC_ERR_CNT_EN
        ,
        .CNT_CLR (cntClr),
        .ERR_CNT (errCnt)
`endif
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compareCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_oval"}, {15'd0, oval}, 16'd0);
        checkOutput({name, "_do"},   {8'd0, dout},  16'd0);
        checkOutput({name, "_ko"},   {15'd0, ko},   16'd0);
        checkOutput({name, "_cerr"}, {15'd0, cerr}, 16'd0);
        checkOutput({name, "_derr"}, {15'd0, derr}, 16'd0);
        checkOutput({name, "_rd"},   {15'd0, rd},   16'd0);
`ifdef DEC_ERR_CNT_EN
        checkOutput({name, "_errcnt"}, errCnt, 16'd0);
`endif
    endtask

    task automatic applyStimulus(input logic [9:0] d, input logic [7:0] expDo, input logic doCare,
                                 input logic expKo, input logic expCerr, input logic expDerr,
                                 input logic expRd);
        expT e;
        e.di     = d;
        e.dout   = expDo;
        e.doCare = doCare;
        e.ko     = expKo;
        e.cerr   = expCerr;
        e.derr   = expDerr;
        e.rd     = expRd;
        expQ.push_back(e);
        di   = d;
        ival = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        compareCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: every OVAL cycle must match the oldest outstanding expectation
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (rstN && oval) begin
                if (expQ.size() == 0) begin
                    compareCount++;
                    missCount++;
                    $display("[TB] FAIL unexpected_oval: got output %h with no pending symbol, expected none", dout);
                end else begin
                    e = expQ.pop_front();
                    if (e.doCare) begin
                        checkOutput($sformatf("do_%h", e.di), {8'd0, dout}, {8'd0, e.dout});
                    end
                    checkOutput($sformatf("ko_%h", e.di),   {15'd0, ko},   {15'd0, e.ko});
                    checkOutput($sformatf("cerr_%h", e.di), {15'd0, cerr}, {15'd0, e.cerr});
                    checkOutput($sformatf("derr_%h", e.di), {15'd0, derr}, {15'd0, e.derr});
                    checkOutput($sformatf("rd_%h", e.di),   {15'd0, rd},   {15'd0, e.rd});
                end
            end
        end
    end

    // Watchdog so the run always ends on its own
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        rstN = 1'b0;
        ival = 1'b0;
        di   = 10'h000;
`ifdef DEC_ERR_CNT_EN
        cntClr = 1'b0;
`endif
        @(negedge clk);
        checkReset("por");
        @(posedge clk);
        #1;
        rstN = 1'b1;

        //            DI       DO     care K  C  D  RD
        applyStimulus(10'h274, 8'h00, 1, 0, 0, 0, 0);   // D.0.0 RD-
        applyStimulus(10'h0FA, 8'hBC, 1, 1, 0, 0, 1);   // K28.5 RD-
        applyStimulus(10'h305, 8'hBC, 1, 1, 0, 0, 0);   // K28.5 RD+
        applyStimulus(10'h0FA, 8'hBC, 1, 1, 0, 0, 1);   // K28.5 RD-
        applyStimulus(10'h0FA, 8'hBC, 1, 1, 0, 1, 1);   // K28.5 RD- sent at RD+
        applyStimulus(10'h000, 8'h00, 0, 0, 1, 1, 0);   // all zeros
        applyStimulus(10'h2AA, 8'hB5, 1, 0, 0, 0, 0);   // D.21.5
        applyStimulus(10'h237, 8'hF1, 1, 0, 0, 0, 1);   // D.17.A7 RD-
        applyStimulus(10'h314, 8'h03, 1, 0, 0, 0, 0);   // D.3.0 RD+
        applyStimulus(10'h3A8, 8'hF7, 1, 1, 0, 0, 0);   // K23.7 RD-
        applyStimulus(10'h0F1, 8'h00, 0, 1, 1, 0, 0);   // K28 with P7: not in table
        applyStimulus(10'h27F, 8'h00, 0, 0, 1, 1, 1);   // 4b sub-block all ones
        applyStimulus(10'h296, 8'hC5, 1, 0, 0, 0, 1);   // D.5.6

        // One idle cycle: outputs hold, OVAL drops
        ival = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("hold_oval", {15'd0, oval}, 16'd0);
        checkOutput("hold_do",   {8'd0, dout},  16'h00C5);
        checkOutput("hold_rd",   {15'd0, rd},   16'd1);

        applyStimulus(10'h238, 8'h00, 0, 0, 1, 0, 0);   // D.17 with A7 at RD+: not in table
        ival = 1'b0;
        drainQueue();

        // Reset mid-stream after RD has gone positive
        applyStimulus(10'h0FA, 8'hBC, 1, 1, 0, 0, 1);
        ival = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkReset("mid_reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Symbol presented, then reset lands before it is captured: it must vanish
        di   = 10'h0FA;
        ival = 1'b1;
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        ival = 1'b0;
        checkReset("inflight_discard");
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(10'h0FA, 8'hBC, 1, 1, 0, 0, 1);   // decoded against RD- again
        applyStimulus(10'h000, 8'h00, 0, 0, 1, 1, 0);
        applyStimulus(10'h000, 8'h00, 0, 0, 1, 1, 0);
        applyStimulus(10'h000, 8'h00, 0, 0, 1, 1, 0);

`ifdef DEC_ERR_CNT_EN
        ival = 1'b0;
        @(negedge clk);
        checkOutput("err_cnt_three", errCnt, 16'd3);
        cntClr = 1'b1;
        applyStimulus(10'h000, 8'h00, 0, 0, 1, 1, 0);
        cntClr = 1'b0;
        ival   = 1'b0;
        @(negedge clk);
        checkOutput("err_cnt_clear", errCnt, 16'd0);
`endif

        ival = 1'b0;
        drainQueue();

        $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
        $finish;
    end

endmodule

// File: doc/decoder_10b8b.md
DECODER_10B8B -- requirements
Module: decoder_10b8b

Interface
Parameters:
REQ-001 SHALL have parameter RD_INIT, default 1'b0; running disparity after reset (0 = RD-, 1 = RD+).
Ports (name, direction, width, meaning):
REQ-002 SHALL have CLK, input, 1; single clock, all state on rising edge.
REQ-003 SHALL have RST_N, input, 1; asynchronous active-low reset.
REQ-004 SHALL have IVAL, input, 1; DI holds a symbol to decode this cycle.
REQ-005 SHALL have DI, input, 10; symbol {a,b,c,d,e,i,f,g,h,j}, a = DI[9], j = DI[0].
REQ-006 SHALL have OVAL, output, 1; DO/KO/CERR/DERR are valid.
REQ-007 SHALL have DO, output, 8; decoded byte {H,G,F,E,D,C,B,A}, A = DO[0].
REQ-008 SHALL have KO, output, 1; decoded symbol is a control (K) character.
REQ-009 SHALL have CERR, output, 1; code violation (not in the 8b/10b code table).
REQ-010 SHALL have DERR, output, 1; disparity violation against the current running disparity.
REQ-011 SHALL have RD, output, 1; current running disparity, 1 = RD+.

Function
REQ-012 SHALL register DO, KO, CERR, DERR, OVAL: outputs appear exactly one cycle after the IVAL cycle, with OVAL = registered IVAL.
REQ-013 SHALL hold DO, KO, CERR, DERR when IVAL = 0; OVAL deasserts in the following cycle.
REQ-014 SHALL decode the 6b sub-block to EDCBA and the 4b sub-block to HGF per the IEEE 802.3 Clause 36 tables; both disparity variants of each code decode identically.
REQ-015 SHALL decode D.x.A7 (fghj 0111/1000) to HGF = 111.
REQ-016 SHALL set KO when abcdei = 001111 or 110000 (K28.y).
REQ-017 SHALL also set KO when fghj is 0111 or 1000 and abcdei is the K23/K27/K29/K30 code (111010, 110110, 101110, 011110, or their complements).
REQ-018 SHALL set CERR when a sub-block's ones count is outside {2,3,4} for 6b or outside {1,2,3} for 4b.
REQ-019 SHALL also set CERR for any 6b/4b pair, including a K pair, absent from the code table.
REQ-020 SHALL set DERR when the 6b sub-block is checked against RD and:
- it has more zeros than ones while RD- (or more ones while RD+); or
- it equals 000111 at RD+ or 111000 at RD-.
REQ-021 SHALL then check the 4b sub-block the same way, using the RD after the 6b sub-block (including 0011 at RD+ and 1100 at RD-).
REQ-022 SHALL update RD only on IVAL cycles, once per sub-block: more ones → RD+, more zeros → RD-, balanced → unchanged. The update applies even when CERR or DERR is set.
REQ-023 SHALL present RD as a register that reflects the update from the symbol in the same cycle OVAL is asserted for it.
REQ-024 SHALL output a best-effort decode on DO for erroneous symbols; errors do not halt decoding.
REQ-025 SHALL accept symbols on back-to-back cycles with no bubbles.

Reset
REQ-026 SHALL, while RST_N = 0 (asynchronously), drive OVAL = 0, DO = 8'h00, KO = 0, CERR = 0, DERR = 0, RD = RD_INIT.
REQ-027 SHALL discard any symbol in flight when reset asserts mid-stream.
REQ-028 SHALL decode the first IVAL cycle after reset release against RD_INIT.

Configuration
REQ-029 SHALL use macro DEC_ERR_CNT_EN; when defined, SHALL add input CNT_CLR (1 bit) and output ERR_CNT (16 bits).
REQ-030 SHALL, with DEC_ERR_CNT_EN defined, increment ERR_CNT by one per accepted symbol with CERR or DERR set.
REQ-031 SHALL saturate ERR_CNT at 16'hFFFF.
REQ-032 SHALL give CNT_CLR priority over a simultaneous increment; ERR_CNT reads 0 the cycle after CNT_CLR.
REQ-033 SHALL reset ERR_CNT to 0 via RST_N.
REQ-034 SHALL, without DEC_ERR_CNT_EN, omit CNT_CLR, ERR_CNT and the counter logic entirely; all other behaviour is identical.

Verification
REQ-035 SHALL cover: reset, RD_INIT = 0, DI = 10'h274 (D.0.0 RD-) → next cycle OVAL = 1, DO = 8'h00, KO = 0, CERR = 0, DERR = 0, RD = 0.
REQ-036 SHALL cover: DI = 10'h0FA then 10'h305 back-to-back (K28.5 RD-, then RD+) → DO = 8'hBC, KO = 1 on both, no errors; RD = 1 then 0.
REQ-037 SHALL cover: DI = 10'h0FA twice → second output DERR = 1, CERR = 0, DO = 8'hBC; RD = 1.
REQ-038 SHALL cover: DI = 10'h000 → CERR = 1; RD = 0.
REQ-039 SHALL cover: after 10'h0FA (RD = 1), assert RST_N = 0 for one cycle mid-stream → OVAL = 0, RD = 0; next 10'h0FA decodes with DERR = 0.
REQ-040 SHALL cover, with DEC_ERR_CNT_EN: three error symbols → ERR_CNT = 3; then CNT_CLR coincident with an error symbol → ERR_CNT = 0.
